// File: rtl/bidir_seq_pkg.sv
// Shared types and frame constants for the bidirectional pad sequencer.
// Latency: n/a (definitions only). Backpressure: n/a.
// BIDIR_SEQ_PARITY_EN adds one even-parity bit to both frame directions.
package bidir_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TX,
      TURN,
      RX_WAIT,
      RX_START,
      RX
   } seq_state_e;

   localparam int DATA_BITS = 8;

`ifdef BIDIR_SEQ_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   // start + data + parity + stop
   localparam int TX_FRAME_BITS = DATA_BITS + PAR_BITS + 2;
   // bits collected before the stop bit is judged
   localparam int RX_SHIFT_BITS = DATA_BITS + PAR_BITS;

endpackage

// File: rtl/bidir_seq_sync2.sv
// Two-flop synchronizer for the pad input; resets to the idle-high line level.
// Latency: 2 cycles. Backpressure: none (free-running).
module bidir_seq_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/bidir_pad_sequencer.sv
// Half-duplex pad sequencer: send a command frame, turn the pad around, receive one response frame.
// Latency: IE/OQI registered one edge after the handshake; IZ decisions lag the pad by 2 cycles.
// Backpressure: TX_READY low for the whole transaction; TX_VALID while busy is dropped. Parity via BIDIR_SEQ_PARITY_EN.
module bidir_pad_sequencer
   import bidir_seq_pkg::*;
#(
   parameter int CLKS_PER_BIT    = 16,
   parameter int TA_BITS         = 2,
   parameter int RX_TIMEOUT_BITS = 32
) (
   input  logic       CLK,
   input  logic       RSTN,
   input  logic [7:0] TX_DATA,
   input  logic       TX_VALID,
   output logic       TX_READY,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       RX_TIMEOUT,
   output logic       RX_FRAME_ERR,
   output logic       BUSY,
   output logic       IE,
   output logic       OQI,
   output logic       INEN,
   input  logic       IZ
);

   localparam int TMR_W = $clog2(TA_BITS * CLKS_PER_BIT) + 1;
   localparam int TO_W  = $clog2(RX_TIMEOUT_BITS * CLKS_PER_BIT + 2) + 1;
   localparam int CNT_W = 4;

   localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] TURN_LAST = TMR_W'(TA_BITS * CLKS_PER_BIT - 1);
   // The window is measured at the pad, so the synchronizer delay is added on top.
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RX_TIMEOUT_BITS * CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(RX_SHIFT_BITS);

   seq_state_e state_q, state_d;
   logic [TMR_W-1:0]         tmr_q, tmr_d;
   logic [CNT_W-1:0]         bcnt_q, bcnt_d;
   logic [TO_W-1:0]          to_q, to_d;
   logic [TX_FRAME_BITS-1:0] tx_sh_q, tx_sh_d;
   logic [RX_SHIFT_BITS-1:0] rx_sh_q, rx_sh_d;
   logic [7:0]               rx_data_q, rx_data_d;
   logic rx_valid_q, rx_valid_d;
   logic rx_timeout_q, rx_timeout_d;
   logic rx_ferr_q, rx_ferr_d;
   logic tx_ready_q, tx_ready_d;
   logic busy_q, busy_d;
   logic ie_q, ie_d;
   logic oqi_q, oqi_d;
   logic inen_q, inen_d;

   logic                     iz_s;
   logic                     accept;
   logic                     rx_ok;
   logic [TX_FRAME_BITS-1:0] tx_frame;

   bidir_seq_sync2 u_sync (
      .clk   (CLK),
      .rst_n (RSTN),
      .d     (IZ),
      .q     (iz_s)
   );

`ifdef BIDIR_SEQ_PARITY_EN
   assign tx_frame = {1'b1, ^TX_DATA, TX_DATA, 1'b0};
   assign rx_ok    = iz_s && !(^rx_sh_q);
`else
   assign tx_frame = {1'b1, TX_DATA, 1'b0};
   assign rx_ok    = iz_s;
`endif

   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q + 1'b1;
      bcnt_d       = bcnt_q;
      to_d         = to_q;
      tx_sh_d      = tx_sh_q;
      rx_sh_d      = rx_sh_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      rx_timeout_d = 1'b0;
      rx_ferr_d    = 1'b0;
      tx_ready_d   = 1'b0;
      accept       = TX_VALID && tx_ready_q;

      case (state_q)
         IDLE: begin
            tmr_d      = '0;
            tx_ready_d = !accept;
            if (accept) begin
               state_d = TX;
               tx_sh_d = tx_frame;
               bcnt_d  = '0;
            end
         end
         TX: begin
            if (tmr_q == BIT_LAST) begin
               tmr_d = '0;
               if (bcnt_q == TX_LAST) begin
                  state_d = TURN;
               end else begin
                  bcnt_d  = bcnt_q + 1'b1;
                  tx_sh_d = tx_sh_q >> 1;
               end
            end
         end
         TURN: begin
            if (tmr_q == TURN_LAST) begin
               tmr_d   = '0;
               to_d    = '0;
               state_d = RX_WAIT;
            end
         end
         RX_WAIT: begin
            tmr_d = '0;
            to_d  = to_q + 1'b1;
            if (to_q >= TO_LAST) begin
               rx_timeout_d = 1'b1;
               state_d      = IDLE;
            end else if (!iz_s) begin
               state_d = RX_START;
            end
         end
         RX_START: begin
            // Timeout keeps running so repeated glitches cannot stall the link.
            to_d = to_q + 1'b1;
            if (tmr_q == HALF_LAST) begin
               tmr_d   = '0;
               bcnt_d  = '0;
               state_d = iz_s ? RX_WAIT : RX;
            end
         end
         RX: begin
            if (tmr_q == BIT_LAST) begin
               tmr_d = '0;
               if (bcnt_q == RX_LAST) begin
                  state_d = IDLE;
                  if (rx_ok) begin
                     rx_data_d  = rx_sh_q[DATA_BITS-1:0];
                     rx_valid_d = 1'b1;
                  end else begin
                     rx_ferr_d = 1'b1;
                  end
               end else begin
                  rx_sh_d = {iz_s, rx_sh_q[RX_SHIFT_BITS-1:1]};
                  bcnt_d  = bcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      ie_d   = (state_d == TX);
      oqi_d  = (state_d == TX) ? tx_sh_d[0] : 1'b1;
      inen_d = (state_d == TURN) || (state_d == RX_WAIT) ||
               (state_d == RX_START) || (state_d == RX);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q      <= IDLE;
         tmr_q        <= '0;
         bcnt_q       <= '0;
         to_q         <= '0;
         tx_sh_q      <= '1;
         rx_sh_q      <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_timeout_q <= 1'b0;
         rx_ferr_q    <= 1'b0;
         tx_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         ie_q         <= 1'b0;
         oqi_q        <= 1'b1;
         inen_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         bcnt_q       <= bcnt_d;
         to_q         <= to_d;
         tx_sh_q      <= tx_sh_d;
         rx_sh_q      <= rx_sh_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_timeout_q <= rx_timeout_d;
         rx_ferr_q    <= rx_ferr_d;
         tx_ready_q   <= tx_ready_d;
         busy_q       <= busy_d;
         ie_q         <= ie_d;
         oqi_q        <= oqi_d;
         inen_q       <= inen_d;
      end
   end

   assign TX_READY     = tx_ready_q;
   assign RX_DATA      = rx_data_q;
   assign RX_VALID     = rx_valid_q;
   assign RX_TIMEOUT   = rx_timeout_q;
   assign RX_FRAME_ERR = rx_ferr_q;
   assign BUSY         = busy_q;
   assign IE           = ie_q;
   assign OQI          = oqi_q;
   assign INEN         = inen_q;

endmodule

// File: doc/bidir_pad_sequencer.md
# bidir_pad_sequencer

Fabric-side half-duplex controller for one bidirectional pad cell. It drives the cell's output enable (IE), output data (OQI) and input enable (INEN), and samples its combinational input (IZ). Each transaction serialises one command byte onto the pad, releases the pad for a turnaround, then receives one response byte. It is the initiator/transmitter end of a single-wire link whose pad-level behaviour the bidir cell provides.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be an even value of at least 4
- TA_BITS, 2, turnaround length in bit periods, at least 1
- RX_TIMEOUT_BITS, 32, maximum wait for a response start bit, in bit periods

Ports:
- CLK  in  1  single clock
- RSTN  in  1  asynchronous active-low reset
- TX_DATA  in  8  command byte
- TX_VALID  in  1  command request
- TX_READY  out  1  sequencer idle and accepting a command
- RX_DATA  out  8  last good response byte
- RX_VALID  out  1  one-cycle pulse; RX_DATA updated
- RX_TIMEOUT  out  1  one-cycle pulse; no start bit seen
- RX_FRAME_ERR  out  1  one-cycle pulse; bad stop bit or parity
- BUSY  out  1  transaction in progress
- IE  out  1  to cell: drive pad
- OQI  out  1  to cell: pad output value
- INEN  out  1  to cell: enable input path
- IZ  in  1  from cell: pad input value

## Operation
- Frame format, both directions:
  - start bit 0
  - 8 data bits, LSB first
  - optional parity bit (see Configuration)
  - stop bit 1
- States and transitions:
  - IDLE: IE=0, INEN=0, OQI=1, TX_READY=1. A TX_VALID&TX_READY handshake latches TX_DATA and moves to TX.
  - TX: IE=1. OQI shifts out the frame, one bit per CLKS_PER_BIT cycles. After the stop bit, go to TURN.
  - TURN: IE=0, INEN=1. Lasts TA_BITS×CLKS_PER_BIT cycles. IZ is ignored. Then go to RX_WAIT.
  - RX_WAIT: INEN=1. Watch the synchronised IZ for 0.
    - A 0 moves to RX_START.
    - The timeout counter reaching RX_TIMEOUT_BITS×CLKS_PER_BIT cycles pulses RX_TIMEOUT and returns to IDLE.
  - RX_START: wait CLKS_PER_BIT/2 cycles, then re-sample.
    - Still 0: go to RX.
    - Otherwise it was a false start: return to RX_WAIT. The timeout counter is not reset.
  - RX: sample every CLKS_PER_BIT cycles at mid-bit, for the data bits, optional parity bit, and stop bit.
    - Stop=1 and parity OK: RX_DATA loads the byte and RX_VALID pulses.
    - Otherwise: RX_FRAME_ERR pulses and RX_DATA holds its old value.
    - In both cases, return to IDLE.
- IZ is passed through a 2-flop synchronizer before any use.
- BUSY = (state != IDLE).
- IE is never 1 in the same cycle as INEN=1.

## Timing
- Reset values:
  - IE=0, OQI=1, INEN=0
  - TX_READY=0, BUSY=0
  - RX_DATA=0, RX_VALID=0, RX_TIMEOUT=0, RX_FRAME_ERR=0
  - state IDLE
- TX_READY rises on the first clock edge after RSTN deasserts.
- All outputs are registered.
- Handshake accepted at edge n: IE=1 and OQI=0 from edge n+1. TX_READY=0 from edge n+1.
- TX frame length is 10 bits (11 with parity) × CLKS_PER_BIT cycles exactly.
- IZ-to-decision latency is 2 cycles (synchronizer). Mid-bit sampling is counted from the synchronised falling edge.
- The RX_VALID, RX_TIMEOUT and RX_FRAME_ERR pulses are mutually exclusive. Each coincides with the return to IDLE. TX_READY=1 on the following edge.
- TX_VALID while busy is ignored; there is no queueing.
- Reset mid-transaction immediately gives IE=0 and INEN=0, and no pulse is emitted.

## Configuration
- BIDIR_SEQ_PARITY_EN defined:
  - an even-parity bit is inserted after the data bits in TX and expected in RX
  - a parity mismatch raises RX_FRAME_ERR
- BIDIR_SEQ_PARITY_EN undefined: there is no parity bit and no parity logic.

## Structure
- Package bidir_seq_pkg holds:
  - the state enum (IDLE, TX, TURN, RX_WAIT, RX_START, RX)
  - DATA_BITS=8
  - frame-length constants derived from BIDIR_SEQ_PARITY_EN
- Sub-module bidir_seq_sync2: 2-flop synchronizer for IZ, with async active-low reset to 1.
- The bit timer and bit counter are inline in the top level.

## Test plan
- CLKS_PER_BIT=4, send 0xA5: OQI sequence 0,1,0,1,0,0,1,0,1,1 for 4 cycles each, IE=1 for 40 cycles, then IE=0 and INEN=1.
- After turnaround, model drives the frame for 0x3C on IZ: RX_VALID pulses once, RX_DATA=0x3C, TX_READY=1 next cycle.
- IZ held at 1 after turnaround: RX_TIMEOUT pulses after exactly 32×4 + 2 cycles in RX_WAIT; no RX_VALID.
- Response with stop bit 0: RX_FRAME_ERR pulses; RX_DATA keeps the previous 0x3C.
- 1-cycle low glitch on IZ in RX_WAIT: false start rejected; a later valid frame for 0x81 is still received.
- RSTN pulsed low mid-TX: IE=0, OQI=1, INEN=0 immediately; TX_READY=1 one edge after release; no stale pulses.
